wb_trace_capture: RTL and testbench
===================================

Name: wb_trace_capture

Overview:
- Capture/readout block for the pipeline's writeback debug stream: destination register, writeback value, branch and stall flags.
- The processor only emits this stream; this block is its consumer. On an arm pulse it records writeback events into an on-chip FIFO and counts stall cycles and retired writebacks.
- Buffered events drain through a valid/ready read port (HEX display stepper, UART dumper, or testbench).
- Sits beside the processor top, clocked from CLOCK_50.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- CAPTURE_LEN, 16, accepted pushes after which capture ends; 1..65535.

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_en  input  1  writeback event valid this cycle.
- wb_dr  input  3  destination register of event.
- wb_val  input  16  writeback value.
- branch_in  input  1  branch-taken flag, sampled with wb_en.
- stall_in  input  1  pipeline stall flag, sampled every cycle.
- arm  input  1  start/restart capture (level, acted on per cycle).
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  20  {branch, dr[2:0], val[15:0]} of oldest entry.
- fill_level  output  $clog2(DEPTH)+1  entries held.
- overflow  output  1  sticky: event dropped because FIFO full.
- stall_cnt  output  16  stall cycles seen during capture, saturating.
- retire_cnt  output  16  wb_en cycles seen during capture, saturating.
- cap_state  output  2  0=IDLE, 1=CAPTURE, 2=DONE.

Behaviour:
- Reset (async assert, sync-style release on next edge): cap_state=IDLE; pointers, fill_level, stall_cnt, retire_cnt, push counter=0; overflow=0; rd_valid=0; rd_data=0.
- IDLE: no pushes, counters hold. arm=1 -> CAPTURE, with the clear actions below on the same edge.
- Clear on arm in IDLE or DONE:
  - Empty the FIFO and zero both counters, the push counter and overflow.
  - Events and stalls in the arming cycle are not recorded.
- CAPTURE:
  - Push: wb_en=1 and (not full, or pop in the same cycle) -> write {branch_in, wb_dr, wb_val} at wr_ptr and increment the push counter.
  - Drop: wb_en=1 while full and no pop -> entry discarded, overflow<=1. Dropped events do not count toward CAPTURE_LEN.
  - retire_cnt+1 on every wb_en=1 cycle, whether pushed or dropped.
  - stall_cnt+1 on every stall_in=1 cycle.
  - Both counters saturate at 16'hFFFF.
  - arm in CAPTURE is ignored.
- CAPTURE -> DONE on the edge where the push counter reaches CAPTURE_LEN. That final event is stored and counted.
- DONE: no pushes; counters and overflow frozen; reads continue. arm -> CAPTURE (clears as above).
- Read port, show-ahead:
  - rd_valid = fill_level != 0. rd_data = entry at rd_ptr; 0 when empty.
  - Pop when rd_valid && rd_ready. rd_ptr advances; the next entry is visible the following cycle.
  - rd_ready while empty is ignored.
  - Reads are legal in every state.
- Push into an empty FIFO: rd_valid rises one cycle later; no same-cycle bypass.
- Simultaneous push and pop: fill_level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. fill_level spans 0..DEPTH. Full = fill_level==DEPTH.
- Reset mid-capture or mid-read: immediate return to reset values; buffered data lost.

Test Plan:
- Reset, then no arm; drive wb_en=1 for 5 cycles -> cap_state=0, rd_valid=0, retire_cnt=0.
- arm, then 3 events (r1,16'h0005,br0), (r2,16'hFFFF,br1), (r7,16'h1234,br0), rd_ready=0 -> fill_level=3. Drain with rd_ready=1 -> rd_data 20'h10005, 20'hAFFFF, 20'h71234 in order, then rd_valid=0.
- CAPTURE_LEN=16, DEPTH=16, arm, 20 consecutive wb_en, rd_ready=0 -> cap_state=2 after the 16th event, fill_level=16, overflow=0, retire_cnt=16; the 4 later events are ignored.
- CAPTURE_LEN=20, DEPTH=16:
  - 18 events, no reads -> overflow=1, fill_level=16, retire_cnt=18, still CAPTURE.
  - Then one pop plus one push in the same cycle -> push accepted, fill_level stays 16.
- stall_in=1 for 7 cycles during CAPTURE -> stall_cnt=7. Force 65540 stall cycles -> stall_cnt=16'hFFFF.
- Assert reset while fill_level=5 in CAPTURE -> all outputs 0 immediately. After release, arm -> counters restart from 0.

Source files
------------

// File: rtl/wb_trace_capture_if.sv
// Writeback debug stream plus show-ahead read port of the trace capture block.
// master = stream producer / readout consumer side, slave = the capture block.
interface wb_trace_capture_if;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_val;
  logic        branch_in;
  logic        stall_in;
  logic        arm;
  logic        rd_ready;
  logic        rd_valid;
  logic [19:0] rd_data;

  modport master (
    output wb_en, wb_dr, wb_val, branch_in, stall_in, arm, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  wb_en, wb_dr, wb_val, branch_in, stall_in, arm, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/wb_trace_capture.sv
// Armed capture of writeback events into a FIFO with stall/retire counters.
// Push-to-rd_valid latency 1 cycle; events arriving while full are dropped (sticky overflow).
module wb_trace_capture #(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  wb_trace_capture_if.slave        bus,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              retire_cnt,
  output logic [1:0]               cap_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [15:0]     push_cnt_q, push_cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic [15:0]     retire_cnt_q, retire_cnt_d;
  logic            ovf_q, ovf_d;
  logic [19:0]     mem_q [DEPTH];

  logic            capturing, full, pop, push, drop, clear;
  logic [19:0]     wr_dat;

  always_comb begin
    capturing = (state_q == CAPTURE);
    full      = (fill_q == FW'(DEPTH));
    pop       = (fill_q != '0) && bus.rd_ready;
    push      = capturing && bus.wb_en && (!full || pop);
    drop      = capturing && bus.wb_en && full && !pop;
    clear     = bus.arm && (state_q != CAPTURE);
    wr_dat    = {bus.branch_in, bus.wb_dr, bus.wb_val};
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    push_cnt_d   = push_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    retire_cnt_d = retire_cnt_q;
    ovf_d        = ovf_q;
    // Arming discards any unread data and ignores the arming cycle's events.
    if (clear) begin
      state_d      = CAPTURE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fill_d       = '0;
      push_cnt_d   = '0;
      stall_cnt_d  = '0;
      retire_cnt_d = '0;
      ovf_d        = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        push_cnt_d = push_cnt_q + 16'd1;
        if (push_cnt_q + 16'd1 == 16'(CAPTURE_LEN)) state_d = DONE;
      end
      if (push && !pop)      fill_d = fill_q + FW'(1);
      else if (pop && !push) fill_d = fill_q - FW'(1);
      if (capturing) begin
        if (bus.wb_en && retire_cnt_q != 16'hFFFF) retire_cnt_d = retire_cnt_q + 16'd1;
        if (bus.stall_in && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        if (drop) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      push_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      push_cnt_q   <= push_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: rd_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign bus.rd_valid = (fill_q != '0);
  assign bus.rd_data  = (fill_q != '0) ? mem_q[rd_ptr_q] : 20'h0;
  assign fill_level   = fill_q;
  assign overflow     = ovf_q;
  assign stall_cnt    = stall_cnt_q;
  assign retire_cnt   = retire_cnt_q;
  assign cap_state    = state_q;
endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench: instance a has CAPTURE_LEN=16, instance b has CAPTURE_LEN=20 (both DEPTH=16).
module tb_wb_trace_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_trace_capture_if ifa ();
  wb_trace_capture_if ifb ();

  logic [4:0]  fill_a, fill_b;
  logic        ovf_a, ovf_b;
  logic [15:0] stall_a, stall_b, ret_a, ret_b;
  logic [1:0]  st_a, st_b;

  wb_trace_capture #(.DEPTH(16), .CAPTURE_LEN(16)) dut_a (
    .CLOCK_50(clk), .reset(rst), .bus(ifa),
    .fill_level(fill_a), .overflow(ovf_a), .stall_cnt(stall_a),
    .retire_cnt(ret_a), .cap_state(st_a)
  );

  wb_trace_capture #(.DEPTH(16), .CAPTURE_LEN(20)) dut_b (
    .CLOCK_50(clk), .reset(rst), .bus(ifb),
    .fill_level(fill_b), .overflow(ovf_b), .stall_cnt(stall_b),
    .retire_cnt(ret_b), .cap_state(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev_a(input logic [2:0] dr, input logic [15:0] val, input logic br);
    ifa.wb_en = 1'b1; ifa.wb_dr = dr; ifa.wb_val = val; ifa.branch_in = br;
    tick();
    ifa.wb_en = 1'b0;
  endtask

  initial begin
    {ifa.wb_en, ifa.wb_dr, ifa.wb_val, ifa.branch_in, ifa.stall_in, ifa.arm, ifa.rd_ready} = '0;
    {ifb.wb_en, ifb.wb_dr, ifb.wb_val, ifb.branch_in, ifb.stall_in, ifb.arm, ifb.rd_ready} = '0;
    tick();
    tick();
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_valid", 32'(ifa.rd_valid), 32'd0);
    chk("rst_data", 32'(ifa.rd_data), 32'd0);
    chk("rst_fill", 32'(fill_a), 32'd0);
    rst = 1'b0;

    // Events without arm are ignored.
    ifa.wb_en = 1'b1;
    repeat (5) tick();
    ifa.wb_en = 1'b0;
    chk("idle_state", 32'(st_a), 32'd0);
    chk("idle_valid", 32'(ifa.rd_valid), 32'd0);
    chk("idle_retire", 32'(ret_a), 32'd0);

    // Capture length end: 20 events, only 16 stored.
    ifa.arm = 1'b1; tick(); ifa.arm = 1'b0;
    chk("arm_state", 32'(st_a), 32'd1);
    ifa.wb_en = 1'b1;
    repeat (15) tick();
    chk("len15_state", 32'(st_a), 32'd1);
    tick();
    chk("len16_state", 32'(st_a), 32'd2);
    repeat (4) tick();
    ifa.wb_en = 1'b0;
    chk("len_fill", 32'(fill_a), 32'd16);
    chk("len_ovf", 32'(ovf_a), 32'd0);
    chk("len_retire", 32'(ret_a), 32'd16);
    chk("len_state", 32'(st_a), 32'd2);

    // Re-arm from DONE and capture three events, then drain in order.
    ifa.arm = 1'b1; tick(); ifa.arm = 1'b0;
    chk("rearm_fill", 32'(fill_a), 32'd0);
    chk("rearm_retire", 32'(ret_a), 32'd0);
    ev_a(3'd1, 16'h0005, 1'b0);
    chk("first_valid", 32'(ifa.rd_valid), 32'd1);
    ev_a(3'd2, 16'hFFFF, 1'b1);
    ev_a(3'd7, 16'h1234, 1'b0);
    chk("three_fill", 32'(fill_a), 32'd3);
    chk("rd0", 32'(ifa.rd_data), 32'h10005);
    ifa.rd_ready = 1'b1;
    tick();
    chk("rd1", 32'(ifa.rd_data), 32'hAFFFF);
    tick();
    chk("rd2", 32'(ifa.rd_data), 32'h71234);
    tick();
    chk("drain_valid", 32'(ifa.rd_valid), 32'd0);
    chk("drain_data", 32'(ifa.rd_data), 32'd0);
    tick();
    chk("empty_ready_fill", 32'(fill_a), 32'd0);
    ifa.rd_ready = 1'b0;

    // Overflow with CAPTURE_LEN=20: 18 events, two dropped.
    ifb.arm = 1'b1; tick(); ifb.arm = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ifb.wb_en = 1'b1; ifb.wb_dr = 3'(i); ifb.wb_val = 16'h0100 + 16'(i); ifb.branch_in = 1'b0;
      tick();
    end
    ifb.wb_en = 1'b0;
    chk("ovf_flag", 32'(ovf_b), 32'd1);
    chk("ovf_fill", 32'(fill_b), 32'd16);
    chk("ovf_retire", 32'(ret_b), 32'd18);
    chk("ovf_state", 32'(st_b), 32'd1);
    chk("ovf_head", 32'(ifb.rd_data), 32'h00100);
    ifb.wb_en = 1'b1; ifb.wb_dr = 3'd3; ifb.wb_val = 16'hBEEF; ifb.rd_ready = 1'b1;
    tick();
    ifb.wb_en = 1'b0; ifb.rd_ready = 1'b0;
    chk("pp_fill", 32'(fill_b), 32'd16);
    chk("pp_head", 32'(ifb.rd_data), 32'h10101);
    chk("pp_retire", 32'(ret_b), 32'd19);
    chk("pp_state", 32'(st_b), 32'd1);

    // Stall counting and saturation.
    ifb.stall_in = 1'b1;
    repeat (7) tick();
    ifb.stall_in = 1'b0;
    tick();
    chk("stall7", 32'(stall_b), 32'd7);
    ifb.stall_in = 1'b1;
    repeat (65540) tick();
    ifb.stall_in = 1'b0;
    chk("stall_sat", 32'(stall_b), 32'hFFFF);

    // Reset in mid-capture with five entries buffered.
    for (int i = 0; i < 5; i++) ev_a(3'(i), 16'(i), 1'b1);
    chk("pre_rst_fill", 32'(fill_a), 32'd5);
    chk("pre_rst_state", 32'(st_a), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ifa.rd_valid), 32'd0);
    chk("mid_rst_data", 32'(ifa.rd_data), 32'd0);
    chk("mid_rst_fill", 32'(fill_a), 32'd0);
    chk("mid_rst_state", 32'(st_a), 32'd0);
    chk("mid_rst_stall_b", 32'(stall_b), 32'd0);
    chk("mid_rst_ovf_b", 32'(ovf_b), 32'd0);
    chk("mid_rst_ret_b", 32'(ret_b), 32'd0);
    tick();
    rst = 1'b0;
    ifa.arm = 1'b1; tick(); ifa.arm = 1'b0;
    chk("post_arm_state", 32'(st_a), 32'd1);
    chk("post_arm_retire", 32'(ret_a), 32'd0);
    ifa.stall_in = 1'b1;
    ev_a(3'd4, 16'h00AA, 1'b0);
    ifa.stall_in = 1'b0;
    chk("post_retire", 32'(ret_a), 32'd1);
    chk("post_stall", 32'(stall_a), 32'd1);
    chk("post_data", 32'(ifa.rd_data), 32'h400AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
